// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared helpers for Gray-coded counters and pointers.
//   GRAY_MAX_WIDTH : widest counter the helpers support.
//   gray_word_t    : full-width carrier type. Consumers widen their own count
//                    type into it and take the low bits of the result.
//   bin2gray()     : binary to reflected Gray code (value ^ (value >> 1)).
//   all_ones()     : all-ones mask of a given width, used for wrap detection.
// -----------------------------------------------------------------------------
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 64;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  // Zero-extended inputs give zero-extended outputs. Because of that, the low
  // bits of the result are the correct Gray code for any narrower width.
  function automatic gray_word_t bin2gray(input gray_word_t value);
    return value ^ (value >> 1);
  endfunction

  function automatic gray_word_t all_ones(input int unsigned width);
    if (width >= GRAY_MAX_WIDTH) begin
      return '1;
    end
    return (gray_word_t'(1) << width) - gray_word_t'(1);
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// -----------------------------------------------------------------------------
// bin_to_gray
// Combinational binary-to-Gray converter. It is the exact inverse of the
// Gray-to-binary converter on the receiving side of a crossing.
//   DATA_WIDTH : code width in bits.
//   bin        : in,  DATA_WIDTH  binary value.
//   gray       : out, DATA_WIDTH  Gray code of bin.
// -----------------------------------------------------------------------------
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] bin,
  output logic [DATA_WIDTH-1:0] gray
);

  gray_word_t gray_wide;

  assign gray_wide = bin2gray(gray_word_t'(bin));
  assign gray      = gray_wide[DATA_WIDTH-1:0];

  // The upper bits are always zero for a zero-extended input, so they are
  // dropped here.
  generate
    if (DATA_WIDTH < GRAY_MAX_WIDTH) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^gray_wide[GRAY_MAX_WIDTH-1:DATA_WIDTH];
    end
  endgenerate

endmodule

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
// Registered up/down binary counter with a registered Gray-code copy. This is
// the source stage of a Gray-coded clock-domain crossing. gray_o changes by
// exactly one bit per count step, so it may be passed through a synchroniser.
// clear_i and load_i can change several gray_o bits at once. The consuming
// domain must be quiesced around those operations.
//   DATA_WIDTH  : counter width in bits (>= 2).
//   RESET_VALUE : binary value on reset and on clear (extended or truncated
//                 to DATA_WIDTH).
//   clk_i       : in,  1           clock.
//   arst_ni     : in,  1           asynchronous active-low reset.
//   clear_i     : in,  1           synchronous clear to RESET_VALUE.
//   load_i      : in,  1           synchronous load of load_val_i.
//   load_val_i  : in,  DATA_WIDTH  value to load.
//   en_i        : in,  1           count enable, one step per cycle.
//   dir_i       : in,  1           1 = up, 0 = down (used only when en_i = 1).
//   bin_o       : out, DATA_WIDTH  registered binary count.
//   gray_o      : out, DATA_WIDTH  registered Gray code of bin_o.
//   bin_next_o  : out, DATA_WIDTH  combinational next binary value.
//   wrap_o      : out, 1           one-cycle pulse after a step that wrapped.
// Priority per cycle: clear_i > load_i > en_i > hold.
// -----------------------------------------------------------------------------
module gray_counter
  import gray_pkg::*;
#(
  parameter int          DATA_WIDTH  = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_val_i,
  input  logic                  en_i,
  input  logic                  dir_i,
  output logic [DATA_WIDTH-1:0] bin_o,
  output logic [DATA_WIDTH-1:0] gray_o,
  output logic [DATA_WIDTH-1:0] bin_next_o,
  output logic                  wrap_o
);

  generate
    if (DATA_WIDTH < 2 || DATA_WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
      $error("gray_counter: DATA_WIDTH out of range");
    end
  endgenerate

  typedef logic [DATA_WIDTH-1:0] count_t;

  localparam count_t ZERO     = '0;
  localparam count_t ONE      = count_t'(1);
  localparam count_t ALL_ONES = count_t'(all_ones(DATA_WIDTH));
  localparam count_t RST_BIN  = count_t'(RESET_VALUE);
  localparam count_t RST_GRAY = count_t'(bin2gray(gray_word_t'(RST_BIN)));

  count_t bin_q;
  count_t gray_q;
  logic   wrap_q;

  count_t bin_next;
  count_t gray_next;
  logic   wrap_next;

  always_comb begin
    bin_next  = bin_q;
    wrap_next = 1'b0;
    if (clear_i) begin
      bin_next = RST_BIN;
    end else if (load_i) begin
      bin_next = load_val_i;
    end else if (en_i) begin
      if (dir_i) begin
        bin_next  = bin_q + ONE;
        wrap_next = (bin_q == ALL_ONES);
      end else begin
        bin_next  = bin_q - ONE;
        wrap_next = (bin_q == ZERO);
      end
    end
  end

  // The Gray code is computed from bin_next and registered on the same edge as
  // bin_q. That keeps gray_o a pure flop output with no glitches.
  bin_to_gray #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bin_to_gray (
    .bin  (bin_next),
    .gray (gray_next)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      wrap_q <= wrap_next;
    end
  end

  assign bin_o      = bin_q;
  assign gray_o     = gray_q;
  assign bin_next_o = bin_next;
  assign wrap_o     = wrap_q;

endmodule
